// File: rtl/lfsr_engine.sv
// lfsr_engine: unrolled multi-bit LFSR step for CRC, scrambler and PRBS use.
// Each output bit is a fixed XOR of state_in/data_in bits; masks are built at elaboration.
module lfsr_engine #(
    parameter int                    LFSR_WIDTH        = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
    parameter string                 LFSR_CONFIG       = "FIBONACCI",
    parameter int                    LFSR_FEED_FORWARD = 0,
    parameter int                    REVERSE           = 0,
    parameter int                    DATA_WIDTH        = 8,
    parameter string                 STYLE             = "AUTO",
    parameter int                    OUTPUT_REG        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);
    localparam int W = LFSR_WIDTH;
    localparam int D = DATA_WIDTH;
    localparam int N = W + D;
    localparam bit GAL = LFSR_CONFIG == "GALOIS";
    localparam bit FF = LFSR_FEED_FORWARD != 0;
    localparam bit REV = REVERSE != 0;

    if (LFSR_CONFIG != "FIBONACCI" && LFSR_CONFIG != "GALOIS") begin : g_bad_config
        $fatal(1, "lfsr_engine: LFSR_CONFIG must be FIBONACCI or GALOIS");
    end
    if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
        $fatal(1, "lfsr_engine: STYLE must be AUTO, LOOP or REDUCTION");
    end
    if (DATA_WIDTH < 1 || LFSR_WIDTH < 2) begin : g_bad_width
        $fatal(1, "lfsr_engine: need DATA_WIDTH >= 1 and LFSR_WIDTH >= 2");
    end

    // Symbolic run of the serial model: every register bit carries the set of
    // inputs ({data_in, state_in}) it depends on instead of a value.
    function automatic logic [N-1:0] lfsr_mask(input int idx);
        logic [W-1:0][N-1:0] sm;
        logic [D-1:0][N-1:0] om;
        logic [N-1:0]        fb, dm;
        sm = '0;
        om = '0;
        for (int i = 0; i < W; i++) sm[i] = N'(1) << (REV ? W - 1 - i : i);
        for (int t = 0; t < D; t++) begin
            dm = N'(1) << (W + (REV ? t : D - 1 - t));
            if (GAL) begin
                fb = sm[W-1] ^ (FF ? '0 : dm);
                for (int j = W - 1; j > 0; j--) sm[j] = sm[j-1] ^ (LFSR_POLY[j] ? fb : '0);
                sm[0] = LFSR_POLY[0] ? fb : '0;
                om[REV ? t : D - 1 - t] = FF ? fb ^ dm : fb;
            end else begin
                fb = sm[W-1];
                for (int j = 1; j < W; j++) fb ^= LFSR_POLY[j] ? sm[j-1] : '0;
                om[REV ? t : D - 1 - t] = fb ^ dm;
                sm = {sm[W-2:0], FF ? dm : fb ^ dm};
            end
        end
        if (idx < W) return sm[REV ? W - 1 - idx : idx];
        return om[idx - W];
    endfunction

    logic [N-1:0] x;
    logic [N-1:0] y_d;

    assign x = {data_in, state_in};

    if (STYLE == "LOOP") begin : g_loop
        logic [W-1:0] s;
        logic [D-1:0] o;
        logic         fb, d;
        always_comb begin
            s = '0;
            o = '0;
            fb = 1'b0;
            d = 1'b0;
            y_d = '0;
            for (int i = 0; i < W; i++) s[i] = state_in[REV ? W - 1 - i : i];
            for (int t = 0; t < D; t++) begin
                d = data_in[REV ? t : D - 1 - t];
                if (GAL) begin
                    fb = s[W-1] ^ (d & !FF);
                    o[REV ? t : D - 1 - t] = fb ^ (d & FF);
                    s = (s << 1) ^ (fb ? LFSR_POLY : '0);
                end else begin
                    fb = s[W-1] ^ (^(s[W-2:0] & LFSR_POLY[W-1:1]));
                    o[REV ? t : D - 1 - t] = fb ^ d;
                    s = {s[W-2:0], FF ? d : fb ^ d};
                end
            end
            for (int i = 0; i < W; i++) y_d[i] = s[REV ? W - 1 - i : i];
            y_d[N-1:W] = o;
        end
    end else begin : g_reduction
        for (genvar i = 0; i < N; i++) begin : g_bit
            localparam logic [N-1:0] M = lfsr_mask(i);
            assign y_d[i] = ^(x & M);
        end
    end

    if (OUTPUT_REG != 0) begin : g_reg
        logic [N-1:0] y_q;
        always_ff @(posedge clk) y_q <= rst ? '0 : y_d;
        assign {data_out, state_out} = y_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst};
        assign {data_out, state_out} = y_d;
    end
endmodule

// File: tb/tb_lfsr_engine.sv
// tb_lfsr_engine: directed and model-based checks of lfsr_engine in CRC, PRBS,
// scrambler and registered-output configurations.
module tb_lfsr_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Serial reference model, widths up to 64
    function automatic logic [63:0] mdl(input bit gal, input bit ff, input bit rev, input int w,
                                        input int dw, input logic [63:0] poly, input logic [63:0] st,
                                        input logic [63:0] din, output logic [63:0] dout);
        logic [63:0] s, r, msk;
        logic        f, d;
        int          k;
        msk = (64'd1 << w) - 64'd1;
        s = '0;
        r = '0;
        dout = '0;
        for (int i = 0; i < w; i++) s[i] = st[rev ? w - 1 - i : i];
        for (int t = 0; t < dw; t++) begin
            k = rev ? t : dw - 1 - t;
            d = din[k];
            if (gal) begin
                f = s[w-1] ^ (ff ? 1'b0 : d);
                s = ((s << 1) ^ (f ? poly : 64'd0)) & msk;
                dout[k] = ff ? f ^ d : f;
            end else begin
                f = s[w-1];
                for (int j = 1; j < w; j++) if (poly[j]) f ^= s[j-1];
                dout[k] = f ^ d;
                s = ((s << 1) | {63'd0, ff ? d : f ^ d}) & msk;
            end
        end
        for (int i = 0; i < w; i++) r[i] = s[rev ? w - 1 - i : i];
        return r;
    endfunction

    function automatic logic [31:0] crc8m(input logic [31:0] st, input logic [7:0] b, output logic [7:0] dout);
        logic [63:0] s, d;
        s = mdl(1'b1, 1'b0, 1'b1, 32, 8, 64'h04C11DB7, {32'd0, st}, {56'd0, b}, d);
        dout = d[7:0];
        return s[31:0];
    endfunction

    // Ethernet CRC, byte lane (reduction and loop styles) and 32-bit lane
    logic [31:0] c8_st, c8_sto, lp_sto;
    logic [7:0]  c8_din, c8_do, lp_do;
    lfsr_engine #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .REVERSE(1),
                  .DATA_WIDTH(8)) u_crc8 (.clk(clk), .rst(rst), .data_in(c8_din), .state_in(c8_st),
                  .data_out(c8_do), .state_out(c8_sto));
    lfsr_engine #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .REVERSE(1),
                  .DATA_WIDTH(8), .STYLE("LOOP")) u_loop (.clk(clk), .rst(rst), .data_in(c8_din),
                  .state_in(c8_st), .data_out(lp_do), .state_out(lp_sto));

    logic [31:0] c32_st, c32_din, c32_sto, c32_do;
    lfsr_engine #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .REVERSE(1),
                  .DATA_WIDTH(32)) u_crc32 (.clk(clk), .rst(rst), .data_in(c32_din), .state_in(c32_st),
                  .data_out(c32_do), .state_out(c32_sto));

    // PRBS7
    logic [6:0] pr_st, pr_sto;
    logic [0:0] pr_din, pr_do;
    lfsr_engine #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .DATA_WIDTH(1)) u_prbs (.clk(clk), .rst(rst),
                  .data_in(pr_din), .state_in(pr_st), .data_out(pr_do), .state_out(pr_sto));

    // x^58+x^39+1 scrambler feeding a descrambler
    logic [57:0] sc_st, sc_sto, ds_st, ds_sto;
    logic [63:0] sc_din, sc_do, ds_do;
    lfsr_engine #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .DATA_WIDTH(64)) u_scr (.clk(clk),
                  .rst(rst), .data_in(sc_din), .state_in(sc_st), .data_out(sc_do), .state_out(sc_sto));
    lfsr_engine #(.LFSR_WIDTH(58), .LFSR_POLY(58'h8000000001), .LFSR_FEED_FORWARD(1), .DATA_WIDTH(64))
        u_dscr (.clk(clk), .rst(rst), .data_in(sc_do), .state_in(ds_st), .data_out(ds_do), .state_out(ds_sto));

    // Galois feed-forward, non-reflected, and all-default instance
    logic [15:0] gf_st, gf_sto;
    logic [7:0]  gf_din, gf_do;
    lfsr_engine #(.LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("GALOIS"), .LFSR_FEED_FORWARD(1),
                  .DATA_WIDTH(8)) u_gff (.clk(clk), .rst(rst), .data_in(gf_din), .state_in(gf_st),
                  .data_out(gf_do), .state_out(gf_sto));
    logic [30:0] df_st, df_sto;
    logic [7:0]  df_din, df_do;
    lfsr_engine u_def (.clk(clk), .rst(rst), .data_in(df_din), .state_in(df_st), .data_out(df_do),
                       .state_out(df_sto));

    // Registered outputs
    logic [31:0] rg_st, rg_sto;
    logic [7:0]  rg_din, rg_do;
    logic        rg_rst;
    lfsr_engine #(.LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"), .REVERSE(1),
                  .DATA_WIDTH(8), .OUTPUT_REG(1)) u_reg (.clk(clk), .rst(rg_rst), .data_in(rg_din),
                  .state_in(rg_st), .data_out(rg_do), .state_out(rg_sto));

    typedef struct {
        logic [31:0] st;
        logic [7:0]  din;
        logic [31:0] exp_st;
        logic [7:0]  exp_d;
        bit          chk_d;
    } vec_t;

    vec_t        vecs[7];
    logic [7:0]  msg[13];
    logic [63:0] m, md;
    logic [31:0] e, ed;
    logic [7:0]  d8;
    logic [127:0] seen;

    initial begin
        vecs[0] = '{32'h00000000, 8'h00, 32'h00000000, 8'h00, 1'b1};
        vecs[1] = '{32'h00000000, 8'h01, 32'h77073096, 8'h41, 1'b1};
        vecs[2] = '{32'h00000000, 8'h02, 32'hEE0E612C, 8'h82, 1'b1};
        vecs[3] = '{32'h00000000, 8'h40, 32'h76DC4190, 8'h40, 1'b1};
        vecs[4] = '{32'h00000000, 8'h80, 32'hEDB88320, 8'h80, 1'b1};
        vecs[5] = '{32'h00000000, 8'hFF, 32'h2D02EF8D, 8'h3F, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 8'h00, 32'h2DFD1072, 8'h00, 1'b0};
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        pr_din = 1'b0;
        rg_rst = 1'b1;
        rg_st = 32'd0;
        rg_din = 8'h01;

        for (int i = 0; i < 7; i++) begin
            c8_st = vecs[i].st;
            c8_din = vecs[i].din;
            #1;
            check("crc8_state", 64'(c8_sto), 64'(vecs[i].exp_st));
            check("loop_state", 64'(lp_sto), 64'(vecs[i].exp_st));
            if (vecs[i].chk_d) begin
                check("crc8_data", 64'(c8_do), 64'(vecs[i].exp_d));
                check("loop_data", 64'(lp_do), 64'(vecs[i].exp_d));
            end
        end

        e = 32'hFFFFFFFF;
        for (int i = 0; i < 13; i++) begin
            c8_st = e;
            c8_din = msg[i];
            #1;
            e = c8_sto;
            if (i == 8) check("crc_123456789", 64'(e), 64'h340BC6D9);
        end
        check("crc_residue", 64'(e), 64'hDEBB20E3);

        for (int n = 0; n < 201; n++) begin
            c32_st = (n == 0) ? 32'hFFFFFFFF : $urandom;
            c32_din = (n == 0) ? 32'h34333231 : $urandom;
            c8_st = $urandom;
            c8_din = 8'($urandom);
            gf_st = 16'($urandom);
            gf_din = 8'($urandom);
            df_st = 31'($urandom);
            df_din = 8'($urandom);
            #1;
            e = c32_st;
            ed = '0;
            for (int b = 0; b < 4; b++) begin
                e = crc8m(e, c32_din[8*b +: 8], d8);
                ed |= 32'(d8) << (8 * b);
            end
            check("crc32_state", 64'(c32_sto), 64'(e));
            check("crc32_data", 64'(c32_do), 64'(ed));
            e = crc8m(c8_st, c8_din, d8);
            check("rand_crc8", {c8_do, c8_sto}, {24'd0, d8, e});
            check("rand_loop", {lp_do, lp_sto}, {24'd0, d8, e});
            m = mdl(1'b1, 1'b1, 1'b0, 16, 8, 64'h1021, 64'(gf_st), 64'(gf_din), md);
            check("galois_ff", {gf_do, gf_sto}, {md[39:0], m[15:0]});
            m = mdl(1'b0, 1'b0, 1'b0, 31, 8, 64'h10000001, 64'(df_st), 64'(df_din), md);
            check("default_cfg", {df_do, df_sto}, {md[32:0], m[30:0]});
        end

        pr_st = 7'h7F;
        seen = '0;
        seen[127] = 1'b1;
        for (int n = 1; n <= 127; n++) begin
            #1;
            m = mdl(1'b0, 1'b0, 1'b0, 7, 1, 64'h41, 64'(pr_st), 64'd0, md);
            check("prbs_step", 64'(pr_sto), m);
            if (pr_sto == 7'd0) check("prbs_nonzero", 64'(pr_sto), 64'h1);
            if (n < 127 && seen[pr_sto]) check("prbs_repeat_at", 64'(n), 64'd127);
            seen[pr_sto] = 1'b1;
            pr_st = pr_sto;
        end
        check("prbs_period", 64'(pr_st), 64'h7F);

        sc_st = 58'h1234567_89ABCDE;
        ds_st = 58'h3A5A5A5_0F0F0F0;
        for (int n = 0; n < 20; n++) begin
            sc_din = {$urandom, $urandom};
            #1;
            m = mdl(1'b0, 1'b0, 1'b0, 58, 64, 64'h8000000001, 64'(sc_st), sc_din, md);
            check("scramble_data", sc_do, md);
            check("scramble_state", 64'(sc_sto), m);
            if (n > 0) check("descramble", ds_do, sc_din);
            sc_st = sc_sto;
            ds_st = ds_sto;
        end

        @(negedge clk);
        @(negedge clk);
        check("reg_rst_state", 64'(rg_sto), 64'd0);
        check("reg_rst_data", 64'(rg_do), 64'd0);
        rg_rst = 1'b0;
        #1;
        check("reg_no_comb_path", 64'(rg_sto), 64'd0);
        @(negedge clk);
        check("reg_lat_state", 64'(rg_sto), 64'h77073096);
        check("reg_lat_data", 64'(rg_do), 64'h41);
        rg_din = 8'hFF;
        @(negedge clk);
        check("reg_stream", {rg_do, rg_sto}, {24'd0, 8'h3F, 32'h2D02EF8D});
        rg_din = 8'h80;
        rg_rst = 1'b1;
        @(negedge clk);
        check("reg_mid_rst", {rg_do, rg_sto}, 64'd0);
        rg_rst = 1'b0;
        @(negedge clk);
        check("reg_after_rst", {rg_do, rg_sto}, {24'd0, 8'h80, 32'hEDB88320});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
